seq_frame_tx: RTL

//  Serial frame transmitter: the send side of the 1011 sequence-detect link.
//  - Accepts a parallel word over a valid/ready handshake.
//  - Emits a 4-bit sync header 1011, then the payload MSB-first, then idle-low gap bits.
//  - Drives the single-bit serial line that the Moore 1011 detector FSM samples.
//  - Sits between a parallel data source and the serial link.

---
 rtl/seq_frame_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync header, MSB-first payload, optional parity, idle-low gap.
// Optional parity bit after the payload is enabled by defining TX_PARITY_EN.
module seq_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
  parameter int                GAP_CYC  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_out,
  output logic              o_frame,
  output logic              o_done
);

  localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_LEN = (MAX_SD > GAP_CYC) ? MAX_SD : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  generate
    if (GAP_CYC < 1) begin : g_bad_gap
      $error("seq_frame_tx: GAP_CYC must be at least 1");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
      $error("seq_frame_tx: DATA_W must be in 1..32");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                r_par;
  logic                w_par_nxt;
  logic                r_ready;
  logic                r_out;
  logic                r_frame;
  logic                r_done;
  logic                w_ready_nxt;
  logic                w_out_nxt;
  logic                w_frame_nxt;
  logic                w_done_nxt;
  logic                w_sync_bit;

  // Outputs are registered, so they are derived from the next state; r_cnt counts down the cycles left.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - CNT_W'(1);
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (i_valid && r_ready) begin
          w_state_nxt = S_SYNC;
          w_cnt_nxt   = CNT_W'(SYNC_W - 1);
          w_shift_nxt = i_din;
          w_par_nxt   = ^i_din;
        end
      end
      S_SYNC: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = CNT_W'(DATA_W - 1);
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
`ifdef TX_PARITY_EN
          w_state_nxt = S_PAR;
          w_cnt_nxt   = '0;
`else
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CNT_W'(GAP_CYC - 1);
`endif
        end
      end
`ifdef TX_PARITY_EN
      S_PAR: begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = CNT_W'(GAP_CYC - 1);
      end
`endif
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_sync_bit  = |(SYNC_PAT & (SYNC_W'(1) << w_cnt_nxt));
    w_out_nxt   = 1'b0;
    w_frame_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_ready_nxt = (w_state_nxt == S_IDLE);

    // The payload bit goes out from the shift MSB, and the register shifts as that bit is emitted.
    case (w_state_nxt)
      S_SYNC: begin
        w_out_nxt   = w_sync_bit;
        w_frame_nxt = 1'b1;
      end
      S_DATA: begin
        w_out_nxt   = w_shift_nxt[DATA_W-1];
        w_shift_nxt = w_shift_nxt << 1;
        w_frame_nxt = 1'b1;
      end
`ifdef TX_PARITY_EN
      S_PAR: begin
        w_out_nxt   = w_par_nxt;
        w_frame_nxt = 1'b1;
      end
`endif
      S_GAP: begin
        w_done_nxt = (r_state != S_GAP);
      end
      default: begin
        w_out_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ready <= 1'b1;
      r_out   <= 1'b0;
      r_frame <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_ready <= w_ready_nxt;
      r_out   <= w_out_nxt;
      r_frame <= w_frame_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_ready = r_ready;
  assign o_out   = r_out;
  assign o_frame = r_frame;
  assign o_done  = r_done;

endmodule
